cordic_hyp_seq: RTL and testbench
=================================

Name: cordic_hyp_seq

Overview:
- Iteration sequencer for the hyperbolic CORDIC engine.
- Drives the read enable and address of the 32-entry atanh angle ROM and supplies the per-iteration shift amount.
- Issues load and iteration-update strobes to the X/Y/Z datapath, and runs a START/DONE handshake with the upstream unit.
- Handles the hyperbolic repeat iterations (shift 4 and shift 13 are each executed twice).

Parameters:
- P, 32, datapath word width; not used internally, passed through for consistency with the ROM.
- D, 5, ROM address width; iteration index width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- START  input  1  begin a run; sampled only in IDLE.
- NITER  input  D+1  number of iterations; latched on accepted START.
- ABORT  input  1  synchronous cancel of the current run.
- ACK_ITER  input  1  datapath has finished the current iteration update.
- EN_ROM1  output  1  ROM read enable.
- ADRS  output  D  ROM address; equals the current iteration index.
- SHIFT  output  D  right-shift amount for the X/Y cross terms.
- LOAD_REGS  output  1  load initial operands into the datapath.
- EN_ITER  output  1  apply one micro-rotation.
- BUSY  output  1  run in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, RST=1): state=IDLE, counter=0, latched NITER=0. All outputs 0: EN_ROM1, ADRS, SHIFT, LOAD_REGS, EN_ITER, BUSY, DONE.
- All strobe outputs are registered Moore outputs of the state.
- States: IDLE, LOAD, FETCH, EXEC, WAIT, FIN.
- IDLE:
  - START=1 → LOAD; latch n = min(NITER, 2^D); counter=0.
  - START in any other state is ignored.
- LOAD: LOAD_REGS=1 for one cycle.
  - n==0 → FIN.
  - otherwise → FETCH.
- FETCH: EN_ROM1=1 for one cycle; ADRS=counter → EXEC. The ROM data is valid on the next edge.
- EXEC: EN_ITER=1 for one cycle → WAIT.
- WAIT: hold until ACK_ITER=1.
  - If counter==n-1 → FIN.
  - Otherwise counter+1 → FETCH.
  - ACK_ITER is sampled only in WAIT. An ACK asserted during EXEC is ignored.
- FIN: DONE=1 for one cycle → IDLE.
- BUSY=1 in every state except IDLE. DONE is asserted only in FIN.
- ADRS=counter and SHIFT=shift(counter) stay stable from FETCH through WAIT. EN_ROM1 is low outside FETCH, so the ROM output holds.
- Shift map, for index k:
  - k<=3 → k+1
  - 4<=k<=13 → k
  - k>=14 → k-1
  - Result: shifts 4 and 13 are repeated, matching the duplicated ROM entries at indices 3/4 and 13/14.
- Minimum of 3 cycles per iteration (ACK_ITER held high). Total latency from the START edge to DONE = 3n+2 cycles, or 2 cycles when n=0.
- ABORT=1 in any non-IDLE state → IDLE on the next edge. Counter cleared, no DONE, strobes deasserted.
- Priority: ABORT takes precedence over ACK_ITER.
- If RST is asserted mid-run, all outputs return to their reset values immediately (asynchronously).
- NITER values above 2^D are clamped to 2^D: the last ADRS is 31 and the last SHIFT is 30.

Decomposition:
- Shared package cordic_pkg:
  - state enum localparams (IDLE..FIN)
  - REPEAT_IDX_A=3, REPEAT_IDX_B=13
  - ITER_MAX=2^D
- Combinational sub-module cordic_shift_map: index k → SHIFT. Reused by the circular-mode sequencer.

Test Plan:
1. RST pulse during WAIT of iteration 2 → all outputs 0 asynchronously. After release, BUSY=0; a new START runs from ADRS=0.
2. NITER=3, ACK_ITER tied high:
   - ADRS=0,1,2 on EN_ROM1 cycles 2, 5, 8 after the START edge.
   - SHIFT=1,2,3.
   - Exactly 3 EN_ITER pulses; DONE at cycle 11.
3. NITER=16, ACK tied high → SHIFT sequence 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14. One LOAD_REGS, one DONE.
4. NITER=2, ACK_ITER delayed 5 cycles per iteration → state stays in WAIT. EN_ITER pulses once per iteration and ADRS stays stable. DONE at 3·2+2+2·4=16 cycles.
5. NITER=0 → LOAD_REGS pulse then DONE, with no EN_ROM1 or EN_ITER. NITER=40 → clamped: 32 iterations, final ADRS=31, SHIFT=30.
6. ABORT in WAIT of iteration 1 → IDLE next cycle, BUSY=0, no DONE. A START pulse while BUSY=1 is ignored; latched n is unchanged.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration sequencers: FSM state encoding,
// iteration limit and the indices whose hyperbolic iterations are repeated.
package cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam int CORDIC_D     = 5;
    localparam int ITER_MAX     = 2 ** CORDIC_D;
    localparam int REPEAT_IDX_A = 3;
    localparam int REPEAT_IDX_B = 13;

endpackage

// File: rtl/cordic_shift_map.sv
// Maps an iteration index to the hyperbolic right-shift amount; shifts 4 and 13
// appear twice so the sequence stays convergent.
module cordic_shift_map
    import cordic_pkg::*;
#(
    parameter int D = 5
) (
    input  logic [D-1:0] i_k,
    output logic [D-1:0] o_shift
);

    always_comb begin
        o_shift = i_k;
        if (i_k <= D'(REPEAT_IDX_A)) begin
            o_shift = i_k + D'(1);
        end else if (i_k > D'(REPEAT_IDX_B)) begin
            o_shift = i_k - D'(1);
        end
    end

endmodule

// File: rtl/cordic_hyp_seq.sv
// Iteration sequencer for the hyperbolic CORDIC engine: steps the atanh ROM
// address and shift amount, and strobes the X/Y/Z datapath once per iteration.
module cordic_hyp_seq
    import cordic_pkg::*;
#(
    parameter int P = 32,
    parameter int D = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [D:0]   NITER,
    input  logic         ABORT,
    input  logic         ACK_ITER,
    output logic         EN_ROM1,
    output logic [D-1:0] ADRS,
    output logic [D-1:0] SHIFT,
    output logic         LOAD_REGS,
    output logic         EN_ITER,
    output logic         BUSY,
    output logic         DONE,
    output logic [2:0]   DBG_STATE
);

    localparam logic [D:0] N_MAX = (D+1)'(ITER_MAX);

    if (P < 1) begin : g_bad_width
        $error("cordic_hyp_seq: P must be positive");
    end

    state_t       r_state;
    state_t       w_state_nxt;
    logic [D-1:0] r_cnt;
    logic [D-1:0] w_cnt_nxt;
    logic [D:0]   r_n;
    logic [D:0]   w_n_nxt;
    logic [D-1:0] w_shift;
    logic         w_abort;
    logic         w_last;
    logic         w_en_rom;
    logic         w_load;
    logic         w_en_iter;
    logic         w_busy;
    logic         w_done;
    logic [D-1:0] w_adrs_o;
    logic [D-1:0] w_shift_o;

    cordic_shift_map #(.D(D)) u_shift_map (
        .i_k     (r_cnt),
        .o_shift (w_shift)
    );

    assign w_abort   = ABORT && (r_state != ST_IDLE);
    assign w_last    = ({1'b0, r_cnt} == (r_n - (D+1)'(1)));
    assign DBG_STATE = r_state;

    // Handshake: START is taken only in IDLE; DONE pulses once per completed run;
    // ACK_ITER is looked at only in WAIT, so an ACK raised during EXEC is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_n_nxt     = r_n;
        w_en_rom    = 1'b0;
        w_load      = 1'b0;
        w_en_iter   = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_adrs_o    = r_cnt;
        w_shift_o   = w_shift;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (START) begin
                    w_state_nxt = ST_LOAD;
                    w_n_nxt     = (NITER > N_MAX) ? N_MAX : NITER;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = (r_n == '0) ? ST_FIN : ST_FETCH;
            end
            ST_FETCH: begin
                w_en_rom    = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_en_iter   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ACK_ITER) begin
                    if (w_last) begin
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_cnt_nxt   = r_cnt + D'(1);
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over everything, including an ACK arriving in the same cycle.
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_en_rom    = 1'b0;
            w_load      = 1'b0;
            w_en_iter   = 1'b0;
            w_busy      = 1'b0;
            w_done      = 1'b0;
            w_adrs_o    = '0;
            w_shift_o   = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_n       <= '0;
            EN_ROM1   <= 1'b0;
            ADRS      <= '0;
            SHIFT     <= '0;
            LOAD_REGS <= 1'b0;
            EN_ITER   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_n       <= w_n_nxt;
            EN_ROM1   <= w_en_rom;
            ADRS      <= w_adrs_o;
            SHIFT     <= w_shift_o;
            LOAD_REGS <= w_load;
            EN_ITER   <= w_en_iter;
            BUSY      <= w_busy;
            DONE      <= w_done;
        end
    end

endmodule

// File: tb/tb_cordic_hyp_seq.sv
// Bench for cordic_hyp_seq: expected strobe events (kind, ADRS, SHIFT, cycle
// offset from the START edge) are queued per run and popped by a monitor.
module tb_cordic_hyp_seq;
    import cordic_pkg::*;

    localparam int W = 21;
    localparam logic [1:0] K_LOAD  = 2'd0;
    localparam logic [1:0] K_FETCH = 2'd1;
    localparam logic [1:0] K_ITER  = 2'd2;
    localparam logic [1:0] K_DONE  = 2'd3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [5:0] NITER;
    logic       ABORT;
    logic       ACK_ITER;
    logic       EN_ROM1;
    logic [4:0] ADRS;
    logic [4:0] SHIFT;
    logic       LOAD_REGS;
    logic       EN_ITER;
    logic       BUSY;
    logic       DONE;
    logic [2:0] DBG_STATE;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ack_delay = 0;

    // Hand-derived hyperbolic shift sequence for indices 0..31.
    int shift_tab [32] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14,
                           15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30};

    cordic_hyp_seq #(.P(32), .D(5)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .NITER     (NITER),
        .ABORT     (ABORT),
        .ACK_ITER  (ACK_ITER),
        .EN_ROM1   (EN_ROM1),
        .ADRS      (ADRS),
        .SHIFT     (SHIFT),
        .LOAD_REGS (LOAD_REGS),
        .EN_ITER   (EN_ITER),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic busy,
                                        input logic [4:0] a, input logic [4:0] s, input int rel);
        return {kind, busy, a, s, 8'(rel)};
    endfunction

    function automatic string fmt(input logic [W-1:0] e);
        return $sformatf("kind=%0d busy=%0d adrs=%0d shift=%0d cyc=%0d",
                         e[20:19], e[18], e[17:13], e[12:8], e[7:0]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic got(input string what, input logic [W-1:0] act);
        logic [W-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got %s, required no event", what, fmt(act));
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %s, required %s", what, fmt(act), fmt(e));
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (LOAD_REGS) got("load",  ev(K_LOAD,  BUSY, 5'd0, 5'd0,  cyc - start_cyc));
            if (EN_ROM1)   got("fetch", ev(K_FETCH, BUSY, ADRS, SHIFT, cyc - start_cyc));
            if (EN_ITER)   got("iter",  ev(K_ITER,  BUSY, ADRS, SHIFT, cyc - start_cyc));
            if (DONE)      got("done",  ev(K_DONE,  BUSY, 5'd0, 5'd0,  cyc - start_cyc));
        end
    end

    // ---------------- drivers ----------------
    // Datapath model: ACK held high, or one ACK pulse ack_delay cycles after EN_ITER.
    initial begin
        ACK_ITER = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_delay == 0) begin
                ACK_ITER = 1'b1;
            end else begin
                ACK_ITER = 1'b0;
                if (EN_ITER) begin
                    repeat (ack_delay) @(negedge CLK);
                    ACK_ITER = 1'b1;
                    @(negedge CLK);
                    ACK_ITER = 1'b0;
                end
            end
        end
    end

    // stop_k < 0: full run ending in DONE; otherwise events only up to iteration stop_k.
    task automatic push_run(input int niter, input int extra, input int stop_k);
        int n;
        int per;
        int last;
        n    = (niter > 32) ? 32 : niter;
        per  = 3 + extra;
        last = (stop_k >= 0) ? stop_k : n - 1;
        exp_q.push_back(ev(K_LOAD, 1'b1, 5'd0, 5'd0, 1));
        for (int k = 0; k <= last; k++) begin
            exp_q.push_back(ev(K_FETCH, 1'b1, 5'(k), 5'(shift_tab[k]), 2 + k * per));
            exp_q.push_back(ev(K_ITER,  1'b1, 5'(k), 5'(shift_tab[k]), 3 + k * per));
        end
        if (stop_k < 0) begin
            exp_q.push_back(ev(K_DONE, 1'b1, 5'd0, 5'd0, 3 * n + 2 + n * extra));
        end
    endtask

    task automatic start_run(input logic [5:0] niter);
        @(negedge CLK);
        NITER = niter;
        START = 1'b1;
        @(posedge CLK);
        #1;
        start_cyc = cyc;
        START = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge CLK);
            #1;
            c++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d events still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic finish_run(input string name);
        drain(name, 300);
        repeat (3) @(negedge CLK);
        #1;
        check({name, "_busy_idle"}, BUSY, 0);
        check({name, "_state_idle"}, DBG_STATE, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST   = 1'b1;
        START = 1'b0;
        NITER = 6'd0;
        ABORT = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_en_rom1",   EN_ROM1,   0);
        check("rst_adrs",      ADRS,      0);
        check("rst_shift",     SHIFT,     0);
        check("rst_load_regs", LOAD_REGS, 0);
        check("rst_en_iter",   EN_ITER,   0);
        check("rst_busy",      BUSY,      0);
        check("rst_done",      DONE,      0);
        check("rst_state",     DBG_STATE, ST_IDLE);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Basic three-iteration run, ACK held high.
        push_run(3, 0, -1);
        start_run(6'd3);
        finish_run("n3");

        // Sixteen iterations cover both repeat points.
        push_run(16, 0, -1);
        start_run(6'd16);
        finish_run("n16");

        // Zero iterations and a clamped request.
        push_run(0, 0, -1);
        start_run(6'd0);
        finish_run("n0");
        push_run(40, 0, -1);
        start_run(6'd40);
        finish_run("n40");

        // Slow datapath: FSM parks in WAIT with ADRS/SHIFT stable.
        ack_delay = 4;
        push_run(2, 4, -1);
        start_run(6'd2);
        finish_run("slow_ack");

        // Asynchronous reset while waiting on iteration 2.
        push_run(5, 4, 2);
        start_run(6'd5);
        drain("pre_reset", 100);
        check("pre_reset_busy", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_en_rom1",   EN_ROM1,   0);
        check("arst_adrs",      ADRS,      0);
        check("arst_shift",     SHIFT,     0);
        check("arst_load_regs", LOAD_REGS, 0);
        check("arst_en_iter",   EN_ITER,   0);
        check("arst_busy",      BUSY,      0);
        check("arst_done",      DONE,      0);
        check("arst_state",     DBG_STATE, ST_IDLE);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        check("post_reset_busy", BUSY, 0);
        ack_delay = 0;
        push_run(2, 0, -1);
        start_run(6'd2);
        finish_run("post_reset");

        // Abort in WAIT of iteration 1: no DONE may follow.
        ack_delay = 4;
        push_run(4, 4, 1);
        start_run(6'd4);
        drain("pre_abort", 100);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        #1;
        check("abort_busy",  BUSY,      0);
        check("abort_state", DBG_STATE, ST_IDLE);
        check("abort_adrs",  ADRS,      0);
        repeat (8) @(negedge CLK);
        check("abort_quiet_busy", BUSY, 0);
        ack_delay = 0;
        repeat (2) @(negedge CLK);

        // START while busy is ignored; the run keeps n=2.
        push_run(2, 0, -1);
        start_run(6'd2);
        repeat (2) @(negedge CLK);
        NITER = 6'd5;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        finish_run("busy_start");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
